dmem_port_arbiter: RTL and testbench

// - Shares the single-port 32-word data memory between the CPU load/store port and a host

---
 rtl/dmem_port_arbiter_pkg.sv | 25 ++
 rtl/dmem_port_arbiter_if.sv | 54 +++++
 rtl/dmem_port_arbiter_burst_ctr.sv | 34 +++
 rtl/dmem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int AW_DEF         = 5;
  localparam int DW_DEF         = 32;
  localparam int HOST_SLICE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  // Width of a counter that must be able to hold the value 'slice'.
  function automatic int slice_width(input int slice);
    return (slice < 1) ? 1 : $clog2(slice + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, host and memory signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_port_arbiter_if
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          host_start;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [AW:0]   host_len;
  logic          host_wvalid;
  logic [DW-1:0] host_wdata;
  logic          host_wready;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          host_done;
  logic          busy;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_start, host_we, host_addr, host_len, host_wvalid, host_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_wready, host_rvalid, host_rdata, host_done, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_start, host_we, host_addr, host_len, host_wvalid, host_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_wready, host_rvalid, host_rdata, host_done, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_port_arbiter_burst_ctr.sv
// Host burst bookkeeping: current word address, beats still to issue and a
// flag marking the beat that finishes the burst.
module dmem_burst_ctr #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          beat,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW:0] remaining;

  // Latch the burst on start, then step the address (wrapping) and count down per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= len;
    end else if (beat) begin
      addr      <= addr + AW'(1);
      remaining <= remaining - (AW+1)'(1);
    end
  end

  assign last = (remaining == (AW+1)'(1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU load/store port and the
// host burst port. Host bursts have priority, but a waiting CPU request is
// guaranteed a slot after HOST_SLICE consecutive host beats.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int HOST_SLICE = HOST_SLICE_DEF
) (
  input logic          clk,
  input logic          rst_n,
  dmem_port_arbiter_if.slave bus
);

  localparam int SW = slice_width(HOST_SLICE);

  state_t        state;
  owner_t        owner;
  logic          run;
  logic          burst_we;
  logic          host_done_q;
  logic          cpu_rvalid_q;
  logic          host_rvalid_q;
  logic [SW-1:0] slice_cnt;

  logic          stall;
  logic          cpu_gnt;
  logic          host_beat;
  logic          burst_load;
  logic [AW-1:0] burst_addr;
  logic          burst_last;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  assign stall      = (state == BURST) && bus.cpu_req && (slice_cnt == SW'(HOST_SLICE));
  assign cpu_gnt    = run && bus.cpu_req && ((state != BURST) || stall);
  assign host_beat  = (state == BURST) && !stall && (!burst_we || bus.host_wvalid);
  assign burst_load = (state == IDLE) && bus.host_start && (bus.host_len != '0);

  dmem_burst_ctr #(
    .AW(AW)
  ) u_burst_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (burst_load),
    .base (bus.host_addr),
    .len  (bus.host_len),
    .beat (host_beat),
    .addr (burst_addr),
    .last (burst_last)
  );

  // Burst FSM plus the registered status, read-return and starvation-slice state.
  // 'run' holds off the combinational CPU grant until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      run           <= 1'b0;
      burst_we      <= 1'b0;
      host_done_q   <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      slice_cnt     <= '0;
    end else begin
      run           <= 1'b1;
      host_done_q   <= 1'b0;
      cpu_rvalid_q  <= cpu_gnt && !bus.cpu_we;
      host_rvalid_q <= host_beat && !burst_we;

      if ((state != BURST) || !bus.cpu_req || stall) begin
        slice_cnt <= '0;
      end else if (host_beat) begin
        slice_cnt <= slice_cnt + SW'(1);
      end

      case (state)
        IDLE: begin
          if (bus.host_start) begin
            if (bus.host_len != '0) begin
              burst_we <= bus.host_we;
              state    <= BURST;
            end else begin
              host_done_q <= 1'b1;
            end
          end
        end
        BURST: begin
          if (host_beat && burst_last) begin
            host_done_q <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pick the single owner of the memory slot this cycle; CPU grant always wins when issued.
  always_comb begin
    owner = OWN_NONE;
    if (cpu_gnt) begin
      owner = OWN_CPU;
    end else if (host_beat) begin
      owner = OWN_HOST;
    end
  end

  // Drive the memory port from the granted owner only; idle slots present all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CPU: begin
        mem_en    = 1'b1;
        mem_we    = bus.cpu_we;
        mem_addr  = bus.cpu_addr;
        mem_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
      end
      OWN_HOST: begin
        mem_en    = 1'b1;
        mem_we    = burst_we;
        mem_addr  = burst_addr;
        mem_wdata = burst_we ? bus.host_wdata : '0;
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;

  // Read data is gated by its valid so that every output is zero while in reset.
  assign bus.cpu_rdata   = cpu_rvalid_q  ? bus.mem_rdata : '0;
  assign bus.host_rdata  = host_rvalid_q ? bus.mem_rdata : '0;

  assign bus.host_wready = host_beat && burst_we;
  assign bus.host_done   = host_done_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural 32-word memory.
module tb_dmem_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_gnt;
    logic          exp_en;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .HOST_SLICE(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] mem [32] = '{default: '0};
  logic [DW-1:0] mem_rdata_q = '0;
  logic [DW-1:0] ref_mem [32] = '{default: '0};

  wr_t           wq[$];
  logic [DW-1:0] cpu_rq[$];
  logic [DW-1:0] host_rq[$];
  wr_t           wr_exp;

  int checks = 0;
  int errors = 0;

  vec_t          vecs[9];
  logic [DW-1:0] wr_data[7] = '{32'd8, 32'd4, 32'd3, 32'd1, 32'd15, 32'd10, 32'd9};
  logic [AW-1:0] wrap_addr[4] = '{5'd30, 5'd31, 5'd0, 5'd1};

  // Behavioural single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else mem_rdata_q <= mem[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = mem_rdata_q;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event seen, none expected", name);
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic req, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic gnt, input logic en,
                                 input logic mwe, input logic [AW-1:0] maddr);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_gnt = gnt; v.exp_en = en; v.exp_we = mwe; v.exp_addr = maddr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.cpu_req   = v.req;
    bus.cpu_we    = v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    if (v.exp_en && v.we) begin
      wq.push_back(wr_t'{addr: v.addr, data: v.wdata});
      ref_mem[v.addr] = v.wdata;
    end else if (v.exp_en) begin
      cpu_rq.push_back(ref_mem[v.addr]);
    end
  endtask

  task automatic checkVector(input vec_t v, input int i);
    checkBit($sformatf("vec%0d_gnt", i), bus.cpu_gnt, v.exp_gnt);
    checkBit($sformatf("vec%0d_mem_en", i), bus.mem_en, v.exp_en);
    if (v.exp_en) begin
      checkBit($sformatf("vec%0d_mem_we", i), bus.mem_we, v.exp_we);
      checkOutput($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(v.exp_addr));
    end
  endtask

  task automatic driveStart(input logic we, input logic [AW-1:0] base, input logic [AW:0] len);
    bus.host_start = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = base;
    bus.host_len   = len;
  endtask

  // Scoreboard monitor: read returns and memory writes against queued expectations.
  always @(negedge clk) begin
    if (bus.cpu_rvalid || bus.host_rvalid)
      checkBit("rvalid_exclusive", bus.cpu_rvalid & bus.host_rvalid, 1'b0);
    if (bus.cpu_rvalid) begin
      if (cpu_rq.size() == 0) reportUnexpected("cpu_rvalid");
      else checkOutput("cpu_rdata", bus.cpu_rdata, cpu_rq.pop_front());
    end
    if (bus.host_rvalid) begin
      if (host_rq.size() == 0) reportUnexpected("host_rvalid");
      else checkOutput("host_rdata", bus.host_rdata, host_rq.pop_front());
    end
    if (bus.mem_en && bus.mem_we) begin
      if (wq.size() == 0) reportUnexpected("mem_write");
      else begin
        wr_exp = wq.pop_front();
        checkOutput("mem_waddr", 32'(bus.mem_addr), 32'(wr_exp.addr));
        checkOutput("mem_wdata", bus.mem_wdata, wr_exp.data);
      end
    end
  end

  // Main test sequence.
  initial begin
    vecs[0] = mkVec(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0);
    vecs[1] = mkVec(1'b1, 1'b0, 5'd3,  32'h0,        1'b1, 1'b1, 1'b0, 5'd3);
    vecs[2] = mkVec(1'b1, 1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 5'd31);
    vecs[3] = mkVec(1'b1, 1'b0, 5'd31, 32'h0,        1'b1, 1'b1, 1'b0, 5'd31);
    vecs[4] = mkVec(1'b1, 1'b1, 5'd0,  32'h5,        1'b1, 1'b1, 1'b1, 5'd0);
    vecs[5] = mkVec(1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0);
    vecs[6] = mkVec(1'b0, 1'b1, 5'd9,  32'h1234,     1'b0, 1'b0, 1'b0, 5'd0);
    vecs[7] = mkVec(1'b1, 1'b1, 5'd30, 32'hA5A5,     1'b1, 1'b1, 1'b1, 5'd30);
    vecs[8] = mkVec(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0);

    rst_n           = 1'b0;
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.cpu_addr    = 5'd3;
    bus.cpu_wdata   = 32'd1;
    bus.host_start  = 1'b0;
    bus.host_we     = 1'b0;
    bus.host_addr   = '0;
    bus.host_len    = '0;
    bus.host_wvalid = 1'b0;
    bus.host_wdata  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkBit("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
    checkBit("rst_mem_en", bus.mem_en, 1'b0);
    checkBit("rst_busy", bus.busy, 1'b0);
    checkBit("rst_host_done", bus.host_done, 1'b0);
    checkBit("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    checkBit("rst_host_rvalid", bus.host_rvalid, 1'b0);
    checkBit("rst_host_wready", bus.host_wready, 1'b0);
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkBit("release_gnt_before_edge", bus.cpu_gnt, 1'b0);
    wq.push_back(wr_t'{addr: 5'd3, data: 32'd1});
    ref_mem[3] = 32'd1;
    nextCycle();
    @(negedge clk);
    checkBit("release_gnt_after_edge", bus.cpu_gnt, 1'b1);
    checkBit("release_mem_en", bus.mem_en, 1'b1);
    nextCycle();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(vecs[i], i);
      nextCycle();
    end

    $display("[TB] host write burst base=0 len=7");
    bus.cpu_req = 1'b0;
    driveStart(1'b1, 5'd0, 6'd7);
    for (int k = 0; k < 7; k++) begin
      wq.push_back(wr_t'{addr: AW'(k), data: wr_data[k]});
      ref_mem[k] = wr_data[k];
    end
    @(negedge clk);
    checkBit("wr_start_busy", bus.busy, 1'b0);
    checkBit("wr_start_mem_en", bus.mem_en, 1'b0);
    nextCycle();
    bus.host_start  = 1'b0;
    bus.host_wvalid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.host_wdata = wr_data[k];
      @(negedge clk);
      checkBit($sformatf("wr_beat%0d_wready", k), bus.host_wready, 1'b1);
      checkBit($sformatf("wr_beat%0d_done", k), bus.host_done, 1'b0);
      nextCycle();
    end
    bus.host_wvalid = 1'b0;
    @(negedge clk);
    checkBit("wr_done_cycle8", bus.host_done, 1'b1);
    checkBit("wr_drain_mem_en", bus.mem_en, 1'b0);
    nextCycle();
    @(negedge clk);
    checkBit("wr_done_cleared", bus.host_done, 1'b0);
    checkBit("wr_busy_cleared", bus.busy, 1'b0);
    nextCycle();

    $display("[TB] host read burst base=30 len=4 (wrap)");
    driveStart(1'b0, 5'd30, 6'd4);
    for (int k = 0; k < 4; k++) host_rq.push_back(ref_mem[wrap_addr[k]]);
    @(negedge clk);
    nextCycle();
    bus.host_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkBit($sformatf("wrap%0d_mem_en", k), bus.mem_en, 1'b1);
      checkBit($sformatf("wrap%0d_mem_we", k), bus.mem_we, 1'b0);
      checkOutput($sformatf("wrap%0d_mem_addr", k), 32'(bus.mem_addr), 32'(wrap_addr[k]));
      checkBit($sformatf("wrap%0d_rvalid", k), bus.host_rvalid, (k > 0));
      nextCycle();
    end
    @(negedge clk);
    checkBit("wrap_done", bus.host_done, 1'b1);
    checkBit("wrap_last_rvalid", bus.host_rvalid, 1'b1);
    nextCycle();
    @(negedge clk);
    checkBit("wrap_rvalid_cleared", bus.host_rvalid, 1'b0);
    checkBit("wrap_busy_cleared", bus.busy, 1'b0);
    nextCycle();

    $display("[TB] starvation guard, write burst len=20");
    driveStart(1'b1, 5'd8, 6'd20);
    for (int b = 1; b <= 20; b++) begin
      wq.push_back(wr_t'{addr: AW'(8 + b - 1), data: 32'h100 + DW'(b)});
      ref_mem[8 + b - 1] = 32'h100 + DW'(b);
      if (b == 8) begin
        wq.push_back(wr_t'{addr: 5'd2, data: 32'h77});
        ref_mem[2] = 32'h77;
      end
    end
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 5'd2;
    bus.cpu_wdata = 32'h77;
    @(negedge clk);
    nextCycle();
    bus.host_start  = 1'b0;
    bus.host_wvalid = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      bus.host_wdata = 32'h100 + DW'((c <= 9) ? c : c - 1);
      bus.cpu_req    = (c <= 9);
      @(negedge clk);
      checkBit($sformatf("starve_c%0d_gnt", c), bus.cpu_gnt, (c == 9));
      checkBit($sformatf("starve_c%0d_wready", c), bus.host_wready, (c != 9));
      nextCycle();
    end
    bus.cpu_req     = 1'b0;
    bus.host_wvalid = 1'b0;
    @(negedge clk);
    checkBit("starve_done", bus.host_done, 1'b1);
    nextCycle();
    @(negedge clk);
    checkBit("starve_busy_cleared", bus.busy, 1'b0);
    nextCycle();

    $display("[TB] host_start while busy, then len=0");
    driveStart(1'b0, 5'd5, 6'd3);
    for (int k = 5; k < 8; k++) host_rq.push_back(ref_mem[k]);
    @(negedge clk);
    nextCycle();
    driveStart(1'b1, 5'd20, 6'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ignore%0d_mem_addr", k), 32'(bus.mem_addr), 32'(5 + k));
      checkBit($sformatf("ignore%0d_mem_we", k), bus.mem_we, 1'b0);
      nextCycle();
    end
    @(negedge clk);
    checkBit("ignore_done", bus.host_done, 1'b1);
    nextCycle();
    bus.host_start = 1'b0;
    @(negedge clk);
    checkBit("ignore_idle_busy", bus.busy, 1'b0);
    checkBit("ignore_idle_mem_en", bus.mem_en, 1'b0);
    nextCycle();
    driveStart(1'b0, 5'd4, 6'd0);
    @(negedge clk);
    checkBit("len0_done_same_cycle", bus.host_done, 1'b0);
    nextCycle();
    bus.host_start = 1'b0;
    @(negedge clk);
    checkBit("len0_done", bus.host_done, 1'b1);
    checkBit("len0_mem_en", bus.mem_en, 1'b0);
    nextCycle();
    @(negedge clk);
    checkBit("len0_done_cleared", bus.host_done, 1'b0);
    checkBit("len0_mem_en_after", bus.mem_en, 1'b0);
    nextCycle();

    $display("[TB] reset in the middle of a read burst");
    driveStart(1'b0, 5'd8, 6'd4);
    host_rq.push_back(ref_mem[8]);
    @(negedge clk);
    nextCycle();
    bus.host_start = 1'b0;
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    nextCycle();
    rst_n = 1'b0;
    @(negedge clk);
    checkBit("midrst_host_rvalid", bus.host_rvalid, 1'b0);
    checkBit("midrst_busy", bus.busy, 1'b0);
    checkBit("midrst_mem_en", bus.mem_en, 1'b0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 5'd3;
    cpu_rq.push_back(ref_mem[3]);
    @(negedge clk);
    checkBit("postrst_load_gnt", bus.cpu_gnt, 1'b1);
    nextCycle();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checkBit("postrst_load_rvalid", bus.cpu_rvalid, 1'b1);
    nextCycle();
    @(negedge clk);

    checkOutput("write_queue_left", 32'(wq.size()), 32'd0);
    checkOutput("cpu_read_queue_left", 32'(cpu_rq.size()), 32'd0);
    checkOutput("host_read_queue_left", 32'(host_rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
